id_ex_stage: RTL and testbench

- Decode stage plus ID/EX pipeline register of the 16-bit MIPS-like core.
- Sits directly upstream of execute and directly downstream of the register file read ports.
- Drives the register-file read addresses combinationally from the IF/ID instruction and captures the returned operands with decoded control into ID/EX.
- Detects load-use hazards, stalls IF/ID and inserts bubbles.

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode stage with ID/EX pipeline register and load-use hazard detection
module id_ex_stage #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int CSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      if_instr,
  input  logic             if_valid,
  input  logic             flush,
  input  logic             hold,
  output logic [ASIZE-1:0] raddr1,
  output logic [ASIZE-1:0] raddr2,
  input  logic [DSIZE-1:0] rdata1,
  input  logic [DSIZE-1:0] rdata2,
  output logic             stall,
  output logic             ex_valid,
  output logic [2:0]       ex_aluop,
  output logic [DSIZE-1:0] ex_opa,
  output logic [DSIZE-1:0] ex_opb,
  output logic [DSIZE-1:0] ex_sdata,
  output logic [ASIZE-1:0] ex_waddr,
  output logic             ex_wen,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic [DSIZE-1:0] ex_imm,
  output logic [CSIZE-1:0] stall_cnt
);

  // ID/EX register layout: valid, 7 control bits, waddr, opa, opb, sdata, imm
  localparam int W = 1 + 7 + ASIZE + 4 * DSIZE;

  logic [3:0]       op;
  logic [ASIZE-1:0] rd;
  logic [ASIZE-1:0] rs;
  logic [ASIZE-1:0] rt;
  logic [DSIZE-1:0] imm;
  logic             is_r;
  logic [2:0]       dec_aluop;
  logic             dec_wen;
  logic             dec_mrd;
  logic             dec_mwr;
  logic             dec_br;
  logic             src1_used;
  logic             src2_used;
  logic             use_imm;
  logic             hit1;
  logic             hit2;
  logic [W-1:0]     idex_d;
  logic [W-1:0]     idex_q;
  logic [W-1:0]     cap;
  logic [CSIZE-1:0] cnt_d;
  logic [CSIZE-1:0] cnt_q;

  assign op   = if_instr[15:12];
  assign rd   = if_instr[11:8];
  assign rs   = if_instr[7:4];
  assign rt   = if_instr[3:0];
  assign imm  = {{(DSIZE-4){if_instr[3]}}, if_instr[3:0]};
  assign is_r = (op <= 4'h4);

  // Read ports come straight from IF/ID so operands return in the same cycle
  assign raddr1 = rs;
  assign raddr2 = is_r ? rt : rd;

  // Opcode decode; unlisted opcodes fall through as NOPs with all controls low
  always_comb begin
    dec_aluop = 3'd0;
    dec_wen   = 1'b0;
    dec_mrd   = 1'b0;
    dec_mwr   = 1'b0;
    dec_br    = 1'b0;
    src1_used = 1'b0;
    src2_used = 1'b0;
    use_imm   = 1'b0;
    if (is_r) begin
      dec_aluop = op[2:0];
      dec_wen   = (rd != '0);
      src1_used = 1'b1;
      src2_used = 1'b1;
    end else begin
      case (op)
        4'h8: begin
          dec_wen   = (rd != '0);
          src1_used = 1'b1;
          use_imm   = 1'b1;
        end
        4'hA: begin
          dec_wen   = (rd != '0);
          dec_mrd   = 1'b1;
          src1_used = 1'b1;
          use_imm   = 1'b1;
        end
        4'hB: begin
          dec_mwr   = 1'b1;
          src1_used = 1'b1;
          src2_used = 1'b1;
          use_imm   = 1'b1;
        end
        4'hC: begin
          dec_aluop = 3'd1;
          dec_br    = 1'b1;
          src1_used = 1'b1;
          src2_used = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A load in ID/EX whose destination feeds a source of the IF/ID instruction
  assign hit1  = src1_used && (ex_waddr == raddr1);
  assign hit2  = src2_used && (ex_waddr == raddr2);
  assign stall = if_valid && ex_valid && ex_mem_read && (ex_waddr != '0) && (hit1 || hit2);

  // Next ID/EX contents: flush beats hold, hold beats the stall bubble
  always_comb begin
    cap = {if_valid,
           if_valid ? {dec_aluop, dec_wen, dec_mrd, dec_mwr, dec_br} : 7'd0,
           rd, rdata1, use_imm ? imm : rdata2, rdata2, imm};
    idex_d = idex_q;
    if (flush)      idex_d = '0;
    else if (hold)  idex_d = idex_q;
    else if (stall) idex_d = '0;
    else            idex_d = cap;
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign {ex_valid, ex_aluop, ex_wen, ex_mem_read, ex_mem_write, ex_branch,
          ex_waddr, ex_opa, ex_opb, ex_sdata, ex_imm} = idex_q;

  // Count only stalls that actually insert a bubble; stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (stall && !hold && !flush && (cnt_q != {CSIZE{1'b1}}))
      cnt_d = cnt_q + CSIZE'(1);
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a behavioural decode model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, hold;
  logic [15:0] if_instr, rdata1, rdata2;
  logic [3:0]  raddr1, raddr2, ex_waddr;
  logic        stall, ex_valid, ex_wen, ex_mem_read, ex_mem_write, ex_branch;
  logic [2:0]  ex_aluop;
  logic [15:0] ex_opa, ex_opb, ex_sdata, ex_imm, stall_cnt;

  logic [3:0]  s_raddr1, s_raddr2, s_waddr;
  logic        s_stall, s_valid, s_wen, s_mrd, s_mwr, s_br;
  logic [2:0]  s_aluop;
  logic [15:0] s_opa, s_opb, s_sdata, s_imm;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid), .flush(flush), .hold(hold),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2), .stall(stall),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_sdata(ex_sdata),
    .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_imm(ex_imm), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CSIZE(2)) u_sat (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid), .flush(flush), .hold(hold),
    .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(rdata1), .rdata2(rdata2), .stall(s_stall),
    .ex_valid(s_valid), .ex_aluop(s_aluop), .ex_opa(s_opa), .ex_opb(s_opb), .ex_sdata(s_sdata),
    .ex_waddr(s_waddr), .ex_wen(s_wen), .ex_mem_read(s_mrd), .ex_mem_write(s_mwr),
    .ex_branch(s_br), .ex_imm(s_imm), .stall_cnt(s_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [2:0]  aluop;
    logic        wen, mrd, mwr, br;
    logic [3:0]  waddr;
    logic [15:0] opa, opb, sdata, imm;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } ent_t;

  typedef struct packed {
    logic [3:0] ra1, ra2;
    logic       stl;
  } comb_t;

  ent_t  eq[$];
  comb_t cq[$];
  ex_t   m;
  int    m_cnt, m_cnt2;
  int    checks = 0;
  int    errors = 0;
  logic  last_stall = 1'b0;

  // Behavioural next-state model built from the instruction-set table
  task automatic step(input logic r, input logic [15:0] ins, input logic v, input logic f,
                      input logic h, input logic [15:0] d1, input logic [15:0] d2);
    logic [3:0]  op, rd, rs, rt, ra2;
    logic [2:0]  aluop;
    logic        wen, mrd, mwr, br, s1, s2, uimm, stl;
    logic [15:0] sx;
    ex_t         nx;
    rst = r; if_instr = ins; if_valid = v; flush = f; hold = h; rdata1 = d1; rdata2 = d2;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    sx = {{12{ins[3]}}, ins[3:0]};
    aluop = 0; wen = 0; mrd = 0; mwr = 0; br = 0; s1 = 0; s2 = 0; uimm = 0;
    if (op <= 4) begin aluop = op[2:0]; wen = (rd != 0); s1 = 1; s2 = 1; end
    else if (op == 4'h8) begin wen = (rd != 0); s1 = 1; uimm = 1; end
    else if (op == 4'hA) begin wen = (rd != 0); mrd = 1; s1 = 1; uimm = 1; end
    else if (op == 4'hB) begin mwr = 1; s1 = 1; s2 = 1; uimm = 1; end
    else if (op == 4'hC) begin aluop = 3'd1; br = 1; s1 = 1; s2 = 1; end
    ra2 = (op <= 4) ? rt : rd;
    stl = v && m.valid && m.mrd && (m.waddr != 0) &&
          ((s1 && m.waddr == rs) || (s2 && m.waddr == ra2));
    cq.push_back('{ra1: rs, ra2: ra2, stl: stl});
    last_stall = stl;
    if (r) begin
      m = '0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (stl && !h && !f) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (f) m = '0;
      else if (h) m = m;
      else if (stl) m = '0;
      else begin
        nx = '0;
        nx.valid = v;
        if (v) begin nx.aluop = aluop; nx.wen = wen; nx.mrd = mrd; nx.mwr = mwr; nx.br = br; end
        nx.waddr = rd; nx.opa = d1; nx.opb = uimm ? sx : d2; nx.sdata = d2; nx.imm = sx;
        m = nx;
      end
    end
    eq.push_back('{ex: m, cnt: m_cnt[15:0], cnt2: m_cnt2[1:0]});
    @(posedge clk);
    #2;
  endtask

  // Monitor for the registered outputs of both instances
  initial begin
    ent_t e;
    ex_t  a;
    forever begin
      @(posedge clk);
      #1;
      if (eq.size() != 0) begin
        e = eq.pop_front();
        a = '{valid: ex_valid, aluop: ex_aluop, wen: ex_wen, mrd: ex_mem_read, mwr: ex_mem_write,
              br: ex_branch, waddr: ex_waddr, opa: ex_opa, opb: ex_opb, sdata: ex_sdata, imm: ex_imm};
        checks++;
        if (a !== e.ex) begin
          errors++;
          $display("FAIL idex t=%0t got v=%b op=%0d wen=%b rd=%b wr=%b br=%b wa=%h a=%h b=%h s=%h i=%h exp v=%b op=%0d wen=%b rd=%b wr=%b br=%b wa=%h a=%h b=%h s=%h i=%h",
                   $time, a.valid, a.aluop, a.wen, a.mrd, a.mwr, a.br, a.waddr, a.opa, a.opb, a.sdata, a.imm,
                   e.ex.valid, e.ex.aluop, e.ex.wen, e.ex.mrd, e.ex.mwr, e.ex.br, e.ex.waddr, e.ex.opa, e.ex.opb, e.ex.sdata, e.ex.imm);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, e.cnt);
        end
        checks++;
        if (s_cnt !== e.cnt2) begin
          errors++;
          $display("FAIL stall_cnt_sat t=%0t got %0d exp %0d", $time, s_cnt, e.cnt2);
        end
      end
    end
  end

  // Monitor for the combinational read addresses and hazard output
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        checks++;
        if (raddr1 !== c.ra1 || raddr2 !== c.ra2 || stall !== c.stl || s_stall !== c.stl) begin
          errors++;
          $display("FAIL comb t=%0t got ra1=%h ra2=%h stall=%b/%b exp ra1=%h ra2=%h stall=%b",
                   $time, raddr1, raddr2, stall, s_stall, c.ra1, c.ra2, c.stl);
        end
      end
    end
  end

  initial begin
    logic [15:0] ins;
    rst = 1; if_instr = 0; if_valid = 0; flush = 0; hold = 0; rdata1 = 0; rdata2 = 0;
    m = '0; m_cnt = 0; m_cnt2 = 0;
    @(posedge clk);
    #2;
    step(1, 16'h1312, 1, 0, 0, 16'h1111, 16'h2222);
    step(1, 16'h1312, 1, 0, 0, 16'h1111, 16'h2222);
    step(0, 16'h1312, 1, 0, 0, 16'h0010, 16'h0004);
    step(0, 16'h852F, 1, 0, 0, 16'h0007, 16'h0009);
    step(0, 16'h802F, 1, 0, 0, 16'h0007, 16'h0009);
    step(0, 16'hA670, 1, 0, 0, 16'h0100, 16'h0000);
    step(0, 16'h0864, 1, 0, 0, 16'h0003, 16'h0005);
    step(0, 16'h0864, 1, 0, 0, 16'h0003, 16'h0005);
    step(0, 16'hA070, 1, 0, 0, 16'h0100, 16'h0000);
    step(0, 16'h0864, 1, 0, 0, 16'h0003, 16'h0005);
    step(0, 16'hA670, 1, 0, 0, 16'h0100, 16'h0000);
    step(0, 16'h0864, 1, 1, 0, 16'h0003, 16'h0005);
    step(0, 16'h2312, 1, 0, 0, 16'h00F0, 16'h0F0F);
    for (int i = 0; i < 3; i++) step(0, 16'h3456, 1, 0, 1, 16'hDEAD, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'hA670, 1, 0, 0, 16'h0100, 16'h0000);
      step(0, 16'h0864, 1, 0, 0, 16'h0003, 16'h0005);
      step(0, 16'h0864, 1, 0, 0, 16'h0003, 16'h0005);
    end
    step(0, 16'hF000, 1, 0, 0, 16'h1234, 16'h5678);
    step(0, 16'hC123, 1, 0, 0, 16'h0042, 16'h0042);
    step(0, 16'hB2A5, 1, 0, 0, 16'h0042, 16'h0077);
    step(0, 16'h4123, 0, 0, 0, 16'h0001, 16'h0002);
    ins = 16'h0000;
    for (int i = 0; i < 2500; i++) begin
      if (!last_stall || $urandom_range(0, 7) == 0)
        ins = {4'($urandom_range(0, 15)), 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      if ($urandom_range(0, 3) == 0) ins[12] = ins[12] ^ 1'b1;
      step($urandom_range(0, 99) == 0, ins, $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 16'($urandom), 16'($urandom));
    end
    step(0, 16'hF000, 0, 0, 0, 16'h0000, 16'h0000);
    #5;
    checks++;
    if (eq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL drain got eq=%0d cq=%0d exp 0", eq.size(), cq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
